// File: rtl/decode_onehot_strobe_pkg.sv
// Shared types and widths for the one-hot strobe decoder.
package decode_pkg;

  localparam int CNT_W        = 8;
  localparam int STROBE_CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/decode_onehot_strobe_if.sv
// Code handshake plus strobe outputs of the one-hot strobe decoder.
interface decode_onehot_strobe_if
  import decode_pkg::*;
#(
  parameter int W = 3
);

  logic                    en;
  logic [W-1:0]            code;
  logic                    code_valid;
  logic                    code_ready;
  logic [2**W-1:0]         y;
  logic                    busy;
  logic                    done;
  logic [STROBE_CNT_W-1:0] strobe_cnt;

  modport master (
    output en, code, code_valid,
    input  code_ready, y, busy, done, strobe_cnt
  );

  modport slave (
    input  en, code, code_valid,
    output code_ready, y, busy, done, strobe_cnt
  );

endinterface

// File: rtl/decode_onehot_strobe_onehot.sv
// Combinational W-to-2**W decoder; a low enable blanks every line.
module decode_onehot #(
  parameter int W = 3
) (
  input  logic [W-1:0]    i_code,
  input  logic            i_en,
  output logic [2**W-1:0] o_y
);

  // Exactly one line high when enabled, none otherwise.
  always_comb begin
    o_y = '0;
    if (i_en) o_y[i_code] = 1'b1;
  end

endmodule

// File: rtl/decode_onehot_strobe.sv
// Sequencer that latches a code, strobes its one-hot line for HOLD cycles,
// then blanks for GAP cycles before accepting the next code.
//
// state  | meaning
// S_IDLE | waiting for a code; ready whenever en is high
// S_HOLD | decoded line driven; r_cnt counts remaining hold cycles - 1
// S_GAP  | all lines blank; r_cnt counts remaining gap cycles - 1
module decode_onehot_strobe
  import decode_pkg::*;
#(
  parameter int W    = 3,
  parameter int HOLD = 4,
  parameter int GAP  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  decode_onehot_strobe_if.slave        bus
);

  localparam logic [CNT_W-1:0]        HOLD_LOAD  = CNT_W'(HOLD - 1);
  // A zero GAP never enters S_GAP, so its load value is unused.
  localparam logic [CNT_W-1:0]        GAP_LOAD   = (GAP > 0) ? CNT_W'(GAP - 1) : '0;
  localparam logic [CNT_W-1:0]        CNT_ONE    = CNT_W'(1);
  localparam logic [STROBE_CNT_W-1:0] STROBE_ONE = STROBE_CNT_W'(1);

  state_t                  r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic [W-1:0]            r_code, w_code_nxt;
  logic [STROBE_CNT_W-1:0] r_strobe_cnt, w_strobe_cnt_nxt;
  logic                    w_xfer;
  logic                    w_last_hold;
  logic                    w_dec_en;

  // State, dwell counter, latched code and strobe count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_code       <= '0;
      r_strobe_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_code       <= w_code_nxt;
      r_strobe_cnt <= w_strobe_cnt_nxt;
    end
  end

  // Next-state logic; everything holds while en is low.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_code_nxt       = r_code;
    w_strobe_cnt_nxt = r_strobe_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_code_nxt  = bus.code;
          w_cnt_nxt   = HOLD_LOAD;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.en) begin
          if (r_cnt == '0) begin
            w_strobe_cnt_nxt = r_strobe_cnt + STROBE_ONE;
            if (GAP > 0) begin
              w_cnt_nxt   = GAP_LOAD;
              w_state_nxt = S_GAP;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
      end
      S_GAP: begin
        if (bus.en) begin
          if (r_cnt == '0) w_state_nxt = S_IDLE;
          else             w_cnt_nxt   = r_cnt - CNT_ONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state, gated by en (and rst for ready).
  always_comb begin
    w_last_hold    = (r_state == S_HOLD) && (r_cnt == '0);
    w_dec_en       = bus.en && (r_state == S_HOLD);
    bus.code_ready = !rst && bus.en && (r_state == S_IDLE);
    bus.busy       = (r_state != S_IDLE);
    bus.done       = bus.en && w_last_hold;
    bus.strobe_cnt = r_strobe_cnt;
    w_xfer         = bus.code_valid && bus.code_ready;
  end

  decode_onehot #(.W(W)) u_decode (
    .i_code (r_code),
    .i_en   (w_dec_en),
    .o_y    (bus.y)
  );

endmodule
